sdram_pattern_tester: RTL and testbench
=======================================

SDRAM_PATTERN_TESTER -- requirements
Module: sdram_pattern_tester

Interface
REQ-001 SHALL have parameter HADDR_WIDTH, default 24, meaning host address width.
REQ-002 SHALL have parameter LAST_ADDR, default 255, meaning highest address tested (range 0..LAST_ADDR).
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning max cycles waited for read data.
REQ-004 Ports (name direction width meaning):
- clk in 1: sole clock, all logic on rising edge.
- rst_n in 1: synchronous, active-low reset.
- start in 1: begin test run, level-sampled in IDLE/DONE.
- seed in 4: pattern seed, captured at start.
- haddr out HADDR_WIDTH: host address to write and read-address FIFOs.
- busy in 1: write or read-address FIFO full.
- wr_enable out 1: push {haddr, wr_data} to write FIFO.
- wr_data out 16: write data.
- rd_enable out 1: push haddr to read-address FIFO.
- rd_data in 16: read data FIFO head.
- rd_rdy in 1: read data FIFO non-empty.
- rd_ack out 1: pop read data FIFO.
- running out 1: test in progress.
- done out 1: test finished.
- pass out 1: valid when done; 1 = zero mismatches and no timeout.
- timeout out 1: read wait exceeded TIMEOUT.
- err_count out 16: mismatch count, saturating.
- fail_addr out HADDR_WIDTH: address of first mismatch.

Function
REQ-005 SHALL implement states IDLE, WRITE, RD_REQ, RD_WAIT, RD_GAP, DONE.
REQ-006 Pattern SHALL be addr[15:0] XOR {4{seed_q}}, seed_q captured on start.
REQ-007 IDLE or DONE with start=1 SHALL: capture seed, addr:=0, clear err_count/fail_addr/timeout/pass/done, go WRITE.
REQ-008 WRITE with busy=0 SHALL assert wr_enable one cycle with haddr=addr, wr_data=pattern(addr); addr increments next cycle.
REQ-009 WRITE with busy=1 SHALL hold wr_enable=0, addr unchanged.
REQ-010 Write of LAST_ADDR SHALL set addr:=0 and go RD_REQ; no address wrap beyond LAST_ADDR.
REQ-011 RD_REQ with busy=0 SHALL assert rd_enable one cycle with haddr=addr, clear wait counter, go RD_WAIT; busy=1 holds.
REQ-012 Exactly one read SHALL be outstanding at any time.
REQ-013 RD_WAIT with rd_rdy=1 SHALL compare rd_data to pattern(addr), assert rd_ack one cycle, go RD_GAP.
REQ-014 Mismatch SHALL increment err_count (saturate at 16'hFFFF) and, if err_count was 0, load fail_addr:=addr.
REQ-015 RD_GAP SHALL last one cycle (absorbs FIFO empty_n update), then: addr==LAST_ADDR -> DONE, else addr+1 and RD_REQ.
REQ-016 RD_WAIT wait counter reaching TIMEOUT with rd_rdy=0 SHALL set timeout=1 and go DONE.
REQ-017 DONE SHALL assert done=1, pass=(err_count==0 && !timeout); outputs held until next start.
REQ-018 running SHALL be 1 in WRITE, RD_REQ, RD_WAIT, RD_GAP; 0 otherwise.
REQ-019 wr_enable, rd_enable, rd_ack SHALL be mutually exclusive and never asserted outside their states.
REQ-020 start SHALL be ignored while running.
REQ-021 haddr SHALL equal addr zero-extended to HADDR_WIDTH in all states.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force IDLE, addr=0, all strobes 0, done=0, pass=0, timeout=0, running=0, err_count=0, fail_addr=0, seed_q=0.
REQ-023 Reset mid-run SHALL abort immediately with no further FIFO strobes; outstanding read data is not popped.

Verification
REQ-024 LAST_ADDR=3, seed=4'hA, busy=0, ideal memory model -> writes 0xAAAA,0xAAAB,0xAAA8,0xAAA9 at 0..3; 4 reads; done=1, pass=1, err_count=0.
REQ-025 Same, model corrupts addr 2 to 0x0000 -> err_count=1, fail_addr=2, pass=0.
REQ-026 busy=1 for 5 cycles during WRITE at addr 1 -> no wr_enable those cycles, addr 1 written exactly once after release.
REQ-027 TIMEOUT=8, model never raises rd_rdy -> timeout=1, done=1, pass=0 9 cycles after rd_enable.
REQ-028 rst_n=0 during RD_WAIT -> next cycle IDLE, all outputs at reset values; subsequent start reruns from addr 0.
REQ-029 Every read: rd_ack exactly one cycle per rd_enable; never two rd_enable without intervening rd_ack.

Source files
------------

// File: rtl/sdram_pattern_tester_if.sv
// sdram_pattern_tester_if: host-side FIFO bus between the pattern tester and the SDRAM controller.
// The tester drives addresses and strobes; the controller side reports back-pressure and read data.
interface sdram_pattern_tester_if #(
    parameter int HADDR_WIDTH = 24
) ();
    logic [HADDR_WIDTH-1:0] haddr;
    logic                   busy;
    logic                   wr_enable;
    logic [15:0]            wr_data;
    logic                   rd_enable;
    logic [15:0]            rd_data;
    logic                   rd_rdy;
    logic                   rd_ack;
    modport master (
        output haddr, wr_enable, wr_data, rd_enable, rd_ack,
        input  busy, rd_data, rd_rdy
    );
    modport slave (
        input  haddr, wr_enable, wr_data, rd_enable, rd_ack,
        output busy, rd_data, rd_rdy
    );
endinterface

// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: writes an address^seed pattern over 0..LAST_ADDR, reads it back one
// request at a time, and reports mismatch count, first failing address and read timeout.
module sdram_pattern_tester #(
    parameter int HADDR_WIDTH = 24,
    parameter int LAST_ADDR   = 255,
    parameter int TIMEOUT     = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [3:0]             seed,
    sdram_pattern_tester_if.master bus,
    output logic                   running,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [15:0]            err_count,
    output logic [HADDR_WIDTH-1:0] fail_addr
);
    localparam int TW = $clog2(TIMEOUT + 1) + 1;
    typedef enum logic [2:0] {IDLE, WRITE, RD_REQ, RD_WAIT, RD_GAP, DONE} state_t;
    state_t                 state_q;
    logic [HADDR_WIDTH-1:0] addr_q, addr_d, fail_addr_q;
    logic [3:0]             seed_q;
    logic [15:0]            err_q, err_d, pattern;
    logic [TW-1:0]          wait_q;
    logic                   running_q, done_q, pass_q, timeout_q, last, mismatch;
    assign pattern  = 16'(addr_q) ^ {4{seed_q}};
    assign last     = addr_q == HADDR_WIDTH'(LAST_ADDR);
    assign addr_d   = last ? '0 : addr_q + HADDR_WIDTH'(1);
    assign mismatch = bus.rd_data != pattern;
    assign err_d    = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
    // Strobes are qualified by busy/rd_rdy in the same cycle so a full FIFO is never pushed,
    // and by rst_n so a reset edge cannot coincide with a push or pop.
    assign bus.haddr     = addr_q;
    assign bus.wr_data   = pattern;
    assign bus.wr_enable = rst_n && state_q == WRITE && !bus.busy;
    assign bus.rd_enable = rst_n && state_q == RD_REQ && !bus.busy;
    assign bus.rd_ack    = rst_n && state_q == RD_WAIT && bus.rd_rdy;
    assign running   = running_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign err_count = err_q;
    assign fail_addr = fail_addr_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            seed_q      <= '0;
            err_q       <= '0;
            fail_addr_q <= '0;
            wait_q      <= '0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) begin
                    state_q     <= WRITE;
                    seed_q      <= seed;
                    addr_q      <= '0;
                    err_q       <= '0;
                    fail_addr_q <= '0;
                    timeout_q   <= 1'b0;
                    pass_q      <= 1'b0;
                    done_q      <= 1'b0;
                    running_q   <= 1'b1;
                end
                WRITE: if (!bus.busy) begin
                    addr_q <= addr_d;
                    if (last) state_q <= RD_REQ;
                end
                RD_REQ: if (!bus.busy) begin
                    wait_q  <= '0;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: if (bus.rd_rdy) begin
                    state_q <= RD_GAP;
                    if (mismatch) begin
                        err_q <= err_d;
                        if (err_q == '0) fail_addr_q <= addr_q;
                    end
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_q   <= DONE;
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                    pass_q    <= 1'b0;
                    running_q <= 1'b0;
                end else begin
                    wait_q <= wait_q + TW'(1);
                end
                RD_GAP: if (last) begin
                    state_q   <= DONE;
                    done_q    <= 1'b1;
                    pass_q    <= err_q == '0;
                    running_q <= 1'b0;
                end else begin
                    addr_q  <= addr_d;
                    state_q <= RD_REQ;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_pattern_tester.sv
// tb_sdram_pattern_tester: table-driven and randomized runs against a FIFO/memory model,
// plus hand-written busy-hold, timeout and mid-read reset sequences.
module tb_sdram_pattern_tester;
    localparam int LAST = 3;
    localparam int TMO  = 8;
    typedef struct {
        logic [3:0]  sd;
        logic [3:0]  mask;
        logic [15:0] cv;
        int          bpct;
        int          lat;
        int          e_err;
        int          e_fail;
        bit          e_pass;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [3:0]  seed;
    logic        running, done, pass, timeout;
    logic [15:0] err_count;
    logic [23:0] fail_addr;
    int          tests = 0;
    int          fails = 0;
    logic [3:0]  c_mask;
    logic [15:0] c_cv;
    int          c_bpct, c_lat;
    bit          c_noresp, c_hold, c_abort, c_poke;
    logic [39:0] wq[$];
    int          rq[$];
    int          viol, acks, hold_wr, rd_cycle, cyc;
    vec_t        vt[6];
    sdram_pattern_tester_if #(.HADDR_WIDTH(24)) bus ();
    sdram_pattern_tester #(.HADDR_WIDTH(24), .LAST_ADDR(LAST), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .bus(bus),
        .running(running), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr)
    );
    always #5 clk = ~clk;
    function automatic logic [15:0] pat(input logic [3:0] s, input logic [23:0] a);
        return a[15:0] ^ {s, s, s, s};
    endfunction
    task automatic chk(input string tag, input string name, input logic [39:0] act, input logic [39:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask
    task automatic check_idle(input string tag);
        chk(tag, "running", running, 0);
        chk(tag, "done", done, 0);
        chk(tag, "pass", pass, 0);
        chk(tag, "timeout", timeout, 0);
        chk(tag, "err_count", err_count, 0);
        chk(tag, "fail_addr", fail_addr, 0);
        chk(tag, "haddr", bus.haddr, 0);
        chk(tag, "wr_data", bus.wr_data, 0);
        chk(tag, "strobes", {bus.wr_enable, bus.rd_enable, bus.rd_ack}, 0);
    endtask
    task automatic check_status(input string tag, input int e_err, input int e_fail, input bit e_pass, input bit e_to);
        chk(tag, "done", done, 1);
        chk(tag, "running", running, 0);
        chk(tag, "pass", pass, e_pass);
        chk(tag, "timeout", timeout, e_to);
        chk(tag, "err_count", err_count, e_err);
        chk(tag, "fail_addr", fail_addr, e_fail);
    endtask
    task automatic check_logs(input string tag, input logic [3:0] sd);
        chk(tag, "n_writes", wq.size(), LAST + 1);
        for (int i = 0; i < wq.size() && i <= LAST; i++)
            chk(tag, $sformatf("write%0d", i), wq[i], {24'(i), pat(sd, 24'(i))});
        chk(tag, "n_reads", rq.size(), LAST + 1);
        for (int i = 0; i < rq.size() && i <= LAST; i++)
            chk(tag, $sformatf("read%0d", i), rq[i], i);
        chk(tag, "n_acks", acks, rq.size());
        chk(tag, "protocol", viol, 0);
    endtask
    // Memory/FIFO model: stores pushed writes, answers each read after c_lat idle cycles,
    // substituting c_cv at addresses selected by c_mask.
    task automatic run(input logic [3:0] sd);
        logic [23:0] pa;
        logic [15:0] mem[4];
        int          pc, hold_left;
        bit          pv, hold_used, wr, rd, ack;
        wq.delete();
        rq.delete();
        viol = 0; acks = 0; hold_wr = 0; rd_cycle = -1; cyc = 0;
        pa = '0; pc = 0; pv = 0; hold_left = 0; hold_used = 0;
        for (int i = 0; i < 4; i++) mem[i] = 16'hDEAD;
        @(negedge clk);
        seed = sd; start = 1'b1; bus.busy = 1'b0; bus.rd_rdy = 1'b0;
        @(negedge clk);
        while (!done && cyc < 1000) begin
            start = c_poke && running && $urandom_range(1) == 1;
            seed = 4'($urandom);
            bus.busy = hold_left > 0 || int'($urandom_range(99)) < c_bpct;
            bus.rd_rdy = pv && pc == 0 && !c_noresp;
            bus.rd_data = c_mask[pa[1:0]] ? c_cv : mem[pa[1:0]];
            #1;
            wr = bus.wr_enable; rd = bus.rd_enable; ack = bus.rd_ack;
            if (int'(wr) + int'(rd) + int'(ack) > 1) viol++;
            if (ack) begin
                if (!pv || !bus.rd_rdy) viol++;
                pv = 0;
                acks++;
            end else if (pv && pc > 0) pc--;
            if (rd) begin
                if (pv) viol++;
                pv = 1; pa = bus.haddr; pc = c_lat; rd_cycle = cyc;
                rq.push_back(int'(bus.haddr));
            end
            if (wr) begin
                wq.push_back({bus.haddr, bus.wr_data});
                mem[bus.haddr[1:0]] = bus.wr_data;
            end
            if (hold_left > 0) begin
                hold_wr += int'(wr);
                if (bus.haddr != 24'd1) viol++;
                hold_left--;
            end else if (c_hold && !hold_used && wq.size() == 1) begin
                hold_left = 5;
                hold_used = 1;
            end
            if (c_abort && rd_cycle >= 0 && cyc == rd_cycle + 2) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 1000) chk("run", "cycle_budget", cyc, 0);
    endtask
    task automatic cfg(input logic [3:0] m, input logic [15:0] v, input int b, input int l);
        c_mask = m; c_cv = v; c_bpct = b; c_lat = l;
        c_noresp = 0; c_hold = 0; c_abort = 0; c_poke = 0;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
    initial begin
        vt[0] = '{sd: 4'hA, mask: 4'b0000, cv: 16'h0000, bpct: 0,  lat: 0, e_err: 0, e_fail: 0, e_pass: 1'b1};
        vt[1] = '{sd: 4'hA, mask: 4'b0100, cv: 16'h0000, bpct: 0,  lat: 0, e_err: 1, e_fail: 2, e_pass: 1'b0};
        vt[2] = '{sd: 4'h5, mask: 4'b1010, cv: 16'h0000, bpct: 20, lat: 2, e_err: 2, e_fail: 1, e_pass: 1'b0};
        vt[3] = '{sd: 4'h0, mask: 4'b0001, cv: 16'h0000, bpct: 0,  lat: 1, e_err: 0, e_fail: 0, e_pass: 1'b1};
        vt[4] = '{sd: 4'hF, mask: 4'b1111, cv: 16'h0000, bpct: 50, lat: 3, e_err: 4, e_fail: 0, e_pass: 1'b0};
        vt[5] = '{sd: 4'h3, mask: 4'b0000, cv: 16'h1234, bpct: 70, lat: 5, e_err: 0, e_fail: 0, e_pass: 1'b1};
        rst_n = 1'b0; start = 1'b0; seed = 4'h0;
        bus.busy = 1'b0; bus.rd_rdy = 1'b0; bus.rd_data = 16'h0;
        cfg(4'h0, 16'h0, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_idle("idle");
        for (int i = 0; i < 6; i++) begin
            cfg(vt[i].mask, vt[i].cv, vt[i].bpct, vt[i].lat);
            run(vt[i].sd);
            check_status($sformatf("vec%0d", i), vt[i].e_err, vt[i].e_fail, vt[i].e_pass, 1'b0);
            check_logs($sformatf("vec%0d", i), vt[i].sd);
        end
        cfg(4'h0, 16'h0, 0, 0);
        c_hold = 1;
        run(4'h6);
        chk("hold", "writes_while_busy", hold_wr, 0);
        check_status("hold", 0, 0, 1'b1, 1'b0);
        check_logs("hold", 4'h6);
        cfg(4'h0, 16'h0, 30, 0);
        c_noresp = 1;
        run(4'h9);
        check_status("timeout", 0, 0, 1'b0, 1'b1);
        chk("timeout", "n_reads", rq.size(), 1);
        chk("timeout", "rd_to_done_cycles", cyc - rd_cycle, TMO + 1);
        cfg(4'h0, 16'h0, 0, 0);
        c_noresp = 1; c_abort = 1;
        run(4'hC);
        chk("abort", "running_before_reset", running, 1);
        rst_n = 1'b0; bus.busy = 1'b0; bus.rd_rdy = 1'b1; bus.rd_data = 16'h0;
        #1;
        chk("abort", "strobes_in_reset", {bus.wr_enable, bus.rd_enable, bus.rd_ack}, 0);
        @(negedge clk);
        rst_n = 1'b1; bus.rd_rdy = 1'b0;
        #1;
        check_idle("abort");
        cfg(4'h0, 16'h0, 10, 1);
        run(4'hC);
        check_status("rerun", 0, 0, 1'b1, 1'b0);
        check_logs("rerun", 4'hC);
        for (int r = 0; r < 10; r++) begin
            logic [3:0] sd;
            int e_err, e_fail;
            cfg(4'($urandom), 16'($urandom), int'($urandom_range(60)), int'($urandom_range(5)));
            c_poke = 1;
            sd = 4'($urandom);
            e_err = 0; e_fail = 0;
            for (int a = 0; a <= LAST; a++)
                if (c_mask[a] && c_cv != pat(sd, 24'(a))) begin
                    if (e_err == 0) e_fail = a;
                    e_err++;
                end
            run(sd);
            check_status($sformatf("rand%0d", r), e_err, e_fail, e_err == 0, 1'b0);
            check_logs($sformatf("rand%0d", r), sd);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
